cpu_read_sequencer: RTL

Sequences every Z80 read cycle into the CPU data-input bus and drives the CPU data-input byte. It synchronizes the Z80 read strobe into the pll0_250MHz domain and captures the device selects at the start of the cycle. It then inserts a per-device-class number of wait states on the Z80 WAIT line and latches the selected device's byte into a registered output that stays stable until the read ends.

---
 rtl/cpu_read_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/cpu_read_sequencer.sv
// rtl/cpu_read_sequencer.sv - Z80 read-cycle sequencer: strobe sync, wait-state insertion, data latch
// Captures the device selects on a synchronized read rise and returns the selected byte after WS clocks.
module cpu_read_sequencer #(
  parameter int unsigned ROM_WS   = 2,
  parameter int unsigned RAM_WS   = 1,
  parameter int unsigned LOCAL_WS = 0,
  parameter int unsigned S100_WS  = 8
) (
  input  logic       pll0_250MHz,
  input  logic       n_reset,
  input  logic       z80Read,
  input  logic [8:0] cs,
  input  logic [7:0] romData,
  input  logic [7:0] ramaData,
  input  logic [7:0] s100DataIn,
  input  logic [7:0] ledread,
  input  logic [7:0] iobyte,
  input  logic [7:0] usbRxD,
  input  logic [7:0] usbStatus,
  output logic [7:0] outData,
  output logic       z80Wait_n,
  output logic [3:0] srcIdx,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_HOLD} state_t;

  localparam logic [3:0] SRC_NONE = 4'hF;

  state_t     r_state, w_state_nxt;
  logic       r_sync1, r_sync2, r_sync2_d;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_out, w_out_nxt;
  logic       r_wait_n, w_wait_n_nxt;
  logic [3:0] r_src, w_src_nxt;
  logic       w_rise, w_fall;
  logic [3:0] w_enc;
  logic [7:0] w_enc_ws;
  logic [7:0] w_src_data;

  // The strobe is asynchronous; the sync chain is deliberately left out of reset so a
  // read held high across reset is not mistaken for a new rise.
  always_ff @(posedge pll0_250MHz) begin
    r_sync1   <= z80Read;
    r_sync2   <= r_sync1;
    r_sync2_d <= r_sync2;
  end

  assign w_rise = r_sync2 & ~r_sync2_d;
  assign w_fall = ~r_sync2 & r_sync2_d;

  // Lowest set select wins; no select falls back to the S100 bus (index 9).
  always_comb begin
    w_enc = 4'd9;
    for (int i = 8; i >= 0; i--) begin
      if (cs[i]) w_enc = 4'(i);
    end
  end

  always_comb begin
    case (w_enc)
      4'd0:                         w_enc_ws = 8'(ROM_WS);
      4'd4:                         w_enc_ws = 8'(RAM_WS);
      4'd1, 4'd5, 4'd6, 4'd7, 4'd8: w_enc_ws = 8'(LOCAL_WS);
      default:                      w_enc_ws = 8'(S100_WS);
    endcase
  end

  always_comb begin
    case (r_src)
      4'd0:    w_src_data = romData;
      4'd1:    w_src_data = 8'h00;
      4'd4:    w_src_data = ramaData;
      4'd5:    w_src_data = ledread;
      4'd6:    w_src_data = iobyte;
      4'd7:    w_src_data = usbRxD;
      4'd8:    w_src_data = usbStatus;
      default: w_src_data = s100DataIn;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_out_nxt    = r_out;
    w_wait_n_nxt = r_wait_n;
    w_src_nxt    = r_src;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_src_nxt    = w_enc;
          w_cnt_nxt    = w_enc_ws;
          w_wait_n_nxt = (w_enc_ws == 8'd0);
          w_state_nxt  = S_COUNT;
        end
      end
      S_COUNT: begin
        // A fall beats a counter expiring in the same cycle: the CPU has gone away.
        if (w_fall) begin
          w_wait_n_nxt = 1'b1;
          w_src_nxt    = SRC_NONE;
          w_state_nxt  = S_IDLE;
        end else if (r_cnt == 8'd0) begin
          w_out_nxt    = w_src_data;
          w_wait_n_nxt = 1'b1;
          w_state_nxt  = S_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_HOLD: begin
        if (w_fall) begin
          w_src_nxt   = SRC_NONE;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pll0_250MHz) begin
    if (!n_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_out    <= 8'h00;
      r_wait_n <= 1'b1;
      r_src    <= SRC_NONE;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_out    <= w_out_nxt;
      r_wait_n <= w_wait_n_nxt;
      r_src    <= w_src_nxt;
    end
  end

  assign outData   = r_out;
  assign z80Wait_n = r_wait_n;
  assign srcIdx    = r_src;
  assign busy      = (r_state != S_IDLE);

endmodule
